// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared sizes, address helper and scheduler state for the pattern scheduler
//
// Purpose: single source for the 16x16 grid geometry, the 5-bit colour width
//          and the IDLE/SCAN state type used by pattern_scheduler.
// Ports:   none (package).
package pixel_pkg;

   localparam int GRID_DIM = 16;
   localparam int COORD_W  = 4;
   localparam int RGB_W    = 5;
   localparam int ADDR_W   = 8;

   // Highest pixel address and highest coordinate on one axis.
   localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(GRID_DIM * GRID_DIM - 1);
   localparam logic [COORD_W-1:0] COORD_LAST = COORD_W'(GRID_DIM - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } sched_state_t;

   // Pattern RAM address layout is {y, x}.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - non-wrapping 8-bit scan address counter with end-of-row and last flags
//
// Purpose: holds the next pattern RAM address to read during a scan.
// Ports:
//   i_clk     in   clock
//   i_rst_n   in   async active-low reset
//   i_clear   in   restart at address 0 (start of frame)
//   i_enable  in   a read was issued at o_addr this cycle
//   o_addr    out  address of the next read
//   o_remain  out  addresses still to be read in this frame
//   o_last    out  o_addr is the final address of the grid
//   o_x_last  out  o_addr is the last column of a row
module scan_counter
   import pixel_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_enable,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_remain,
   output logic              o_last,
   output logic              o_x_last
);

   logic [ADDR_W-1:0] r_addr;
   logic              r_exhausted;

   // The counter parks on the last address and raises r_exhausted instead of
   // wrapping, so the scan cannot re-read address 0 within the same frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr      <= '0;
         r_exhausted <= 1'b0;
      end else if (i_clear) begin
         r_addr      <= '0;
         r_exhausted <= 1'b0;
      end else if (i_enable && !r_exhausted) begin
         if (r_addr == ADDR_LAST) begin
            r_exhausted <= 1'b1;
         end else begin
            r_addr <= r_addr + 1'b1;
         end
      end
   end

   assign o_addr   = r_addr;
   assign o_remain = !r_exhausted;
   assign o_last   = (r_addr == ADDR_LAST);
   assign o_x_last = (r_addr[COORD_W-1:0] == COORD_LAST);

endmodule

// File: rtl/pattern_scheduler.sv
// rtl/pattern_scheduler.sv - arbitrates pattern RAM between a 16x16 frame scan and a pixel modifier
//
// Purpose: on frame_start, reads every pixel of the pattern RAM in address
//          order and presents it on a valid/ready pixel stream; between reads
//          it grants single-pixel writes from the modifier port.
// Ports:
//   fclock, init_n              clock, async active-low reset
//   frame_start                 pulse: start a full scan (ignored while busy)
//   mod_req/mod_x/mod_y/mod_rgb modifier write request, held until mod_ack
//   mod_ack                     write granted this cycle (combinational)
//   mem_addr/mem_we/mem_wdata   pattern RAM command (combinational)
//   mem_rdata                   pattern RAM read data, one cycle after address
//   pix_valid/pix_x/pix_y/pix_rgb/pix_ready  registered scanned-pixel stream
//   busy                        scan in progress
//   frame_done                  pulse after the last pixel is accepted
module pattern_scheduler
   import pixel_pkg::*;
(
   input  logic               fclock,
   input  logic               init_n,
   input  logic               frame_start,
   input  logic               mod_req,
   input  logic [COORD_W-1:0] mod_x,
   input  logic [COORD_W-1:0] mod_y,
   input  logic [RGB_W-1:0]   mod_rgb,
   output logic               mod_ack,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [RGB_W-1:0]   mem_wdata,
   input  logic [RGB_W-1:0]   mem_rdata,
   output logic               pix_valid,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [RGB_W-1:0]   pix_rgb,
   input  logic               pix_ready,
   output logic               busy,
   output logic               frame_done
);

   sched_state_t      r_state;
   logic              r_reserved;
   logic              r_rd_pend;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_pix_valid;
   logic [ADDR_W-1:0] r_pix_addr;
   logic [RGB_W-1:0]  r_pix_rgb;
   logic              r_skid_valid;
   logic [ADDR_W-1:0] r_skid_addr;
   logic [RGB_W-1:0]  r_skid_rgb;
   logic              r_frame_done;

   logic [ADDR_W-1:0] w_scan_addr;
   logic              w_remain;
   logic              w_last;
   logic              w_x_last;
   logic              w_clear;
   logic              w_rd;
   logic              w_wr;
   logic              w_out_free;
   logic              w_frame_end;

   scan_counter u_scan_counter (
      .i_clk    (fclock),
      .i_rst_n  (init_n),
      .i_clear  (w_clear),
      .i_enable (w_rd),
      .o_addr   (w_scan_addr),
      .o_remain (w_remain),
      .o_last   (w_last),
      .o_x_last (w_x_last)
   );

   assign w_clear    = (r_state == ST_IDLE) && frame_start;
   assign w_out_free = !r_pix_valid || pix_ready;

   // A read may issue when the consumer takes the current pixel this cycle,
   // or when the output is empty with nothing in flight. An empty output
   // with a read already in flight is not treated as free: that keeps a
   // single read outstanding under backpressure, and the skid register only
   // ever has to absorb that one in-flight word.
   assign w_rd = init_n && (r_state == ST_SCAN) && w_remain && !r_reserved &&
                 (pix_ready || (!r_pix_valid && !r_rd_pend));

   // Any cycle without a read belongs to the modifier.
   assign w_wr = init_n && mod_req && !w_rd;

   assign mem_we    = w_wr;
   assign mem_addr  = w_rd ? w_scan_addr : pix_addr(mod_x, mod_y);
   assign mem_wdata = mod_rgb;
   assign mod_ack   = w_wr;

   assign w_frame_end = (r_state == ST_SCAN) && r_pix_valid && pix_ready &&
                        (r_pix_addr == ADDR_LAST);

   always_ff @(posedge fclock or negedge init_n) begin
      if (!init_n) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (frame_start) r_state <= ST_SCAN;
            ST_SCAN: if (w_frame_end) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // The cycle after each end-of-row read is kept free for the modifier,
   // bounding its wait to one row of reads. The slot after the final
   // address is not needed because no reads follow it.
   always_ff @(posedge fclock or negedge init_n) begin
      if (!init_n) begin
         r_reserved <= 1'b0;
      end else begin
         r_reserved <= w_rd && w_x_last && !w_last;
      end
   end

   always_ff @(posedge fclock or negedge init_n) begin
      if (!init_n) begin
         r_rd_pend    <= 1'b0;
         r_rd_addr    <= '0;
         r_pix_valid  <= 1'b0;
         r_pix_addr   <= '0;
         r_pix_rgb    <= '0;
         r_skid_valid <= 1'b0;
         r_skid_addr  <= '0;
         r_skid_rgb   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_rd_pend    <= w_rd;
         r_frame_done <= w_frame_end;
         if (w_rd) begin
            r_rd_addr <= w_scan_addr;
         end
         if (w_out_free) begin
            // Skid and in-flight data never coexist, so the order here only
            // needs to drain the older word first.
            if (r_skid_valid) begin
               r_pix_valid  <= 1'b1;
               r_pix_addr   <= r_skid_addr;
               r_pix_rgb    <= r_skid_rgb;
               r_skid_valid <= 1'b0;
            end else if (r_rd_pend) begin
               r_pix_valid <= 1'b1;
               r_pix_addr  <= r_rd_addr;
               r_pix_rgb   <= mem_rdata;
            end else begin
               r_pix_valid <= 1'b0;
            end
         end else if (r_rd_pend) begin
            // Output stalled when RAM data arrives: park it until the
            // consumer frees the output register.
            r_skid_valid <= 1'b1;
            r_skid_addr  <= r_rd_addr;
            r_skid_rgb   <= mem_rdata;
         end
      end
   end

   assign pix_valid  = r_pix_valid;
   assign pix_x      = r_pix_addr[COORD_W-1:0];
   assign pix_y      = r_pix_addr[ADDR_W-1:COORD_W];
   assign pix_rgb    = r_pix_rgb;
   assign busy       = (r_state == ST_SCAN);
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pattern_scheduler.sv
// tb/tb_pattern_scheduler.sv - directed self-checking bench for pattern_scheduler
module tb_pattern_scheduler;

   logic       fclock = 1'b0;
   logic       init_n;
   logic       frame_start;
   logic       mod_req;
   logic [3:0] mod_x;
   logic [3:0] mod_y;
   logic [4:0] mod_rgb;
   logic       mod_ack;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [4:0] mem_wdata;
   logic [4:0] mem_rdata;
   logic       pix_valid;
   logic [3:0] pix_x;
   logic [3:0] pix_y;
   logic [4:0] pix_rgb;
   logic       pix_ready;
   logic       busy;
   logic       frame_done;

   int n_vec  = 0;
   int n_miss = 0;

   int first_valid;
   int n_acc;
   int n_gap;
   int n_done;
   int done_k;
   int ack_k;
   int n_ack;
   bit aborted;

   logic [4:0] ram [256];
   logic [4:0] exp_ram [256];
   logic [4:0] rdata_q;
   logic       ram_init;

   always #5 fclock = ~fclock;

   pattern_scheduler dut (
      .fclock      (fclock),
      .init_n      (init_n),
      .frame_start (frame_start),
      .mod_req     (mod_req),
      .mod_x       (mod_x),
      .mod_y       (mod_y),
      .mod_rgb     (mod_rgb),
      .mod_ack     (mod_ack),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_rgb     (pix_rgb),
      .pix_ready   (pix_ready),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   // Synchronous pattern RAM: data for an address appears one cycle later.
   always @(posedge fclock) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 5'(i);
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      rdata_q <= ram[mem_addr];
   end
   assign mem_rdata = rdata_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // rmode 0: ready always; 1: ready on even cycles; 2: ready low until cycle 20.
   // Called at posedge+1; returns at posedge+1, or at the negedge where
   // abort_addr is presented (aborted=1).
   task automatic run_frame(input int rmode, input int mod_k, input logic [3:0] mx,
                            input logic [3:0] my, input logic [4:0] mrgb, input int abort_addr);
      int          exp_next;
      bit          prev_stall;
      logic [12:0] prev_pix;
      bit          mod_on;
      first_valid = -1; n_acc = 0; n_gap = 0; n_done = 0; done_k = -1;
      ack_k = -1; n_ack = 0; aborted = 0;
      exp_next = 0; prev_stall = 0; prev_pix = '0; mod_on = 0;
      mod_x = mx; mod_y = my; mod_rgb = mrgb;
      frame_start = 1'b1;
      @(negedge fclock);
      @(posedge fclock); #1;
      frame_start = 1'b0;
      for (int k = 0; k < 700; k++) begin
         case (rmode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = (k % 2 == 0);
            default: pix_ready = (k >= 20);
         endcase
         if (rmode == 2) begin
            mod_req = (mod_k >= 0) && (k >= mod_k) && (k < 20);
         end else begin
            if (k == mod_k) mod_on = 1;
            mod_req = mod_on;
         end
         @(negedge fclock);
         if (mod_ack) begin
            n_ack++;
            if (ack_k < 0) ack_k = k;
            mod_on = 0;
         end
         if (rmode == 2 && k < 20) begin
            chk("stall_ack", 32'(mod_ack), 32'(k >= 1));
            chk("stall_we", 32'(mem_we), 32'(k >= 1));
            chk("stall_valid", 32'(pix_valid), 32'(k >= 2));
         end
         if (prev_stall) chk("hold", 32'({pix_valid, pix_y, pix_x, pix_rgb}), 32'({1'b1, prev_pix}));
         prev_stall = pix_valid && !pix_ready;
         prev_pix   = {pix_y, pix_x, pix_rgb};
         if (pix_valid && first_valid < 0) first_valid = k;
         if (!pix_valid && first_valid >= 0 && n_acc < 256) n_gap++;
         if (pix_valid && pix_ready) begin
            chk("order", 32'({pix_y, pix_x}), exp_next);
            chk("rgb", 32'(pix_rgb), 32'(exp_ram[exp_next[7:0]]));
            exp_next++;
            n_acc++;
         end
         if (abort_addr >= 0 && pix_valid && ({pix_y, pix_x} == abort_addr[7:0])) begin
            aborted = 1;
            break;
         end
         if (frame_done) begin
            n_done++;
            done_k = k;
            chk("done_busy", 32'(busy), 0);
            break;
         end
         @(posedge fclock); #1;
      end
      if (!aborted) begin
         mod_req = 1'b0;
         @(posedge fclock); #1;
         chk("done_pulse", 32'(frame_done), 0);
      end
   endtask

   initial begin
      init_n = 1'b0; ram_init = 1'b1; frame_start = 1'b0; pix_ready = 1'b1;
      mod_req = 1'b1; mod_x = 4'd3; mod_y = 4'd4; mod_rgb = 5'd5;
      for (int a = 0; a < 256; a++) exp_ram[a] = 5'(a);

      // Reset values, with a modifier request pending.
      @(negedge fclock);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_ack", 32'(mod_ack), 0);
      chk("rst_valid", 32'(pix_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_xy", 32'({pix_y, pix_x}), 0);
      chk("rst_rgb", 32'(pix_rgb), 0);
      @(posedge fclock); #1;
      ram_init = 1'b0; mod_req = 1'b0;
      @(negedge fclock);
      init_n = 1'b1;
      @(posedge fclock); #1;

      // Full frame, consumer always ready.
      run_frame(0, -1, 4'd0, 4'd0, 5'd0, -1);
      chk("s1_first", first_valid, 2);
      chk("s1_count", n_acc, 256);
      chk("s1_gaps", n_gap, 15);
      chk("s1_done", n_done, 1);
      chk("s1_done_k", done_k, 273);
      chk("s1_acks", n_ack, 0);

      // Back-to-back modifier writes while idle.
      for (int i = 0; i < 4; i++) begin
         mod_req = 1'b1; mod_x = 4'(i); mod_y = 4'hF; mod_rgb = 5'(8 * i + 1);
         @(negedge fclock);
         chk("idle_ack", 32'(mod_ack), 1);
         chk("idle_we", 32'(mem_we), 1);
         chk("idle_addr", 32'(mem_addr), 32'(8'hF0 + i));
         chk("idle_wdata", 32'(mem_wdata), 32'(8 * i + 1));
         chk("idle_busy", 32'(busy), 0);
         @(posedge fclock); #1;
         exp_ram[8'hF0 + i] = 5'(8 * i + 1);
      end
      mod_req = 1'b0;
      @(negedge fclock);
      chk("idle_noack", 32'(mod_ack), 0);
      chk("idle_nowe", 32'(mem_we), 0);
      @(posedge fclock); #1;

      // Consumer ready toggling every cycle.
      run_frame(1, -1, 4'd0, 4'd0, 5'd0, -1);
      chk("s2_first", first_valid, 2);
      chk("s2_count", n_acc, 256);
      chk("s2_done", n_done, 1);

      // Modifier from cycle 3 to a not-yet-scanned pixel (5,2): granted in
      // the reserved slot after address 15, before address 0x52 is read.
      exp_ram[8'h52] = 5'd7;
      run_frame(0, 3, 4'd2, 4'd5, 5'd7, -1);
      chk("s3_ack_k", ack_k, 16);
      chk("s3_acks", n_ack, 1);
      chk("s3_count", n_acc, 256);
      chk("s3_gaps", n_gap, 15);
      chk("s3_done_k", done_k, 273);

      // Same timing to address 0, already scanned: old value this frame.
      run_frame(0, 3, 4'd0, 4'd0, 5'd9, -1);
      chk("s3b_ack_k", ack_k, 16);
      chk("s3b_count", n_acc, 256);
      exp_ram[0] = 5'd9;

      // Consumer stalled for 20 cycles with a modifier request held.
      exp_ram[8'h11] = 5'h1E;
      run_frame(2, 0, 4'd1, 4'd1, 5'h1E, -1);
      chk("s5_acks", n_ack, 19);
      chk("s5_count", n_acc, 256);
      chk("s5_done", n_done, 1);

      // Reset while pixel 100 is presented.
      run_frame(0, -1, 4'd0, 4'd0, 5'd0, 100);
      chk("s6_aborted", 32'(aborted), 1);
      chk("s6_nodone", n_done, 0);
      init_n = 1'b0; mod_req = 1'b1;
      #1;
      chk("s6_valid", 32'(pix_valid), 0);
      chk("s6_xy", 32'({pix_y, pix_x}), 0);
      chk("s6_rgb", 32'(pix_rgb), 0);
      chk("s6_busy", 32'(busy), 0);
      chk("s6_we", 32'(mem_we), 0);
      chk("s6_ack", 32'(mod_ack), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge fclock);
         @(negedge fclock);
         chk("s6_hold_done", 32'(frame_done), 0);
         chk("s6_hold_busy", 32'(busy), 0);
      end
      mod_req = 1'b0;
      init_n = 1'b1;
      @(posedge fclock); #1;
      run_frame(0, -1, 4'd0, 4'd0, 5'd0, -1);
      chk("s6r_first", first_valid, 2);
      chk("s6r_count", n_acc, 256);
      chk("s6r_done_k", done_k, 273);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/pattern_scheduler.md
PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: fclock (rising edge) and init_n (asserted low, asynchronously).
REQ-002 Ports SHALL be (name  direction  width  meaning):
  fclock  in  1  system clock
  init_n  in  1  async active-low reset
  frame_start  in  1  single-cycle pulse; starts a full 16x16 scan
  mod_req  in  1  modifier write request; held until acked
  mod_x, mod_y  in  4 each  pixel coordinate to write
  mod_rgb  in  5  colour to write
  mod_ack  out  1  write granted this cycle
  mem_addr  out  8  pattern RAM address {y,x}
  mem_we  out  1  pattern RAM write enable
  mem_wdata  out  5  pattern RAM write data
  mem_rdata  in  5  pattern RAM read data, valid 1 cycle after address
  pix_valid  out  1  scanned pixel available
  pix_x, pix_y  out  4 each  coordinate of scanned pixel
  pix_rgb  out  5  colour of scanned pixel
  pix_ready  in  1  display consumer accepts pixel
  busy  out  1  scan in progress
  frame_done  out  1  single-cycle pulse when last pixel accepted
REQ-003 mem_addr, mem_we, mem_wdata and mod_ack SHALL be combinational from state and requests; all other outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have states IDLE and SCAN; busy = (state==SCAN).
REQ-005 IDLE->SCAN SHALL occur on frame_start; the scan address resets to 0. frame_start in SCAN SHALL be ignored.
REQ-006 In SCAN, a read SHALL issue (mem_we=0, mem_addr=scan address, address +1) when addresses remain, the reserved slot is not active, and (!pix_valid || pix_ready).
REQ-007 Exactly one read SHALL be outstanding; the next-cycle mem_rdata SHALL load pix_rgb, pix_x/pix_y = issued address, pix_valid=1.
REQ-008 pix_valid and pix_x/pix_y/pix_rgb SHALL hold stable while pix_valid && !pix_ready.
REQ-009 Sustained throughput SHALL be 1 pixel/cycle with pix_ready high, excluding reserved slots; first pix_valid SHALL occur 2 cycles after frame_start.
REQ-010 A modifier write SHALL be granted (mem_we=1, mem_addr={mod_y,mod_x}, mem_wdata=mod_rgb, mod_ack=1) in any cycle with mod_req=1 and no read issued.
REQ-011 The cycle after a read with x==15 SHALL be reserved: no read issues; the modifier is granted if mod_req=1. Maximum modifier wait during a scan without backpressure SHALL be 16 cycles.
REQ-012 In IDLE, mod_req SHALL be granted every cycle it is asserted (back-to-back writes allowed).
REQ-013 Scan address SHALL NOT wrap: after address 255 is issued, no further reads occur.
REQ-014 When the pixel at address 255 is accepted (pix_valid && pix_ready), frame_done SHALL pulse for one cycle on the next edge and state SHALL return to IDLE.
REQ-015 A write to an address not yet scanned SHALL be visible in the scan. A write to an address already read SHALL take effect only in the next frame.
REQ-016 mod_ack SHALL never assert without mod_req. A read and a write SHALL never share a cycle.

Reset
REQ-017 With init_n low: state=IDLE, scan address=0, pix_valid=0, pix_x=pix_y=0, pix_rgb=0, frame_done=0, busy=0, and combinational mem_we=0, mod_ack=0.
REQ-018 Reset mid-scan SHALL abandon the frame with no frame_done. The first frame_start after release SHALL restart at address 0.

Structure
REQ-019 A shared package pixel_pkg SHALL hold GRID_DIM=16, COORD_W=4, RGB_W=5, ADDR_W=8 and the scheduler state enum.
REQ-020 A sub-module scan_counter (8-bit, clear/enable, last flag, x==15 flag) is natural. All other logic SHALL live in pattern_scheduler.

Verification
REQ-021 The bench SHALL cover these scenarios:
  - Reset, pix_ready=1, frame_start at cycle 0 -> pix_valid from cycle 2, addresses 0..255 in order, 15 reserved gaps, frame_done once, then busy=0.
  - RAM preloaded with rgb=addr[4:0] and pix_ready toggled 1/0 -> every pixel held stable while stalled, no address skipped or duplicated.
  - mod_req held from cycle 3 of a scan with (x=2,y=5,rgb=7) -> ack within 16 cycles; frame shows 7 at (2,5) only if that address was read after the ack.
  - IDLE, mod_req 4 consecutive cycles -> 4 acks, 4 mem_we, no reads.
  - pix_ready=0 throughout the scan, mod_req=1 -> the modifier is acked every cycle after the single outstanding read; pix_valid stays 1.
  - init_n low at pixel 100 -> all outputs at reset values, no frame_done; the next frame_start restarts at address 0.
